stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control sequencer for the lab stopwatch datapath: centisecond, second and minute counters driven by a 50 MHz clock. It conditions two raw push-buttons and runs a four-state machine that produces the datapath's count enable, synchronous clear pulse and display-freeze (lap) signal. It sits between the board buttons and the stopwatch counters/7-segment display path.

## Interface
- `DEBOUNCE_CYCLES`, default 500_000: consecutive stable cycles required before a debounced level changes (10 ms at 50 MHz). Must be ≥ 2.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `btn_ss`  in  1  raw start/stop button, active-high, asynchronous to `clk`.
- `btn_lr`  in  1  raw lap/reset button, active-high, asynchronous to `clk`.
- `count_en`  out  1  datapath counters advance while high.
- `count_clr`  out  1  one-cycle pulse that zeroes the datapath counters.
- `disp_hold`  out  1  display register frozen while high (lap view).
- `state`  out  2  current state: IDLE=00, RUN=01, LAP=10, PAUSE=11.

## Operation
- Each button passes through:
  - a 2-flop synchronizer;
  - a debouncer (see Configuration);
  - a rising-edge detector that produces a one-cycle press event `ev_ss` / `ev_lr`.
- Holding a button produces exactly one event. A second event needs a release and a new press.
- The FSM acts only on events. If `ev_ss` and `ev_lr` occur in the same cycle, `ev_ss` wins and `ev_lr` is discarded.
- Transitions (anything not listed holds state):
  - IDLE: `ev_ss` goes to RUN. `ev_lr` stays in IDLE and issues a `count_clr` pulse.
  - RUN: `ev_ss` goes to PAUSE. `ev_lr` goes to LAP.
  - LAP: `ev_lr` goes to RUN (display released). `ev_ss` goes to PAUSE (display released, counting stops).
  - PAUSE: `ev_ss` goes to RUN (resume, no clear). `ev_lr` goes to IDLE and issues a `count_clr` pulse.
- Outputs are Moore, decoded from the state register:
  - `count_en` = 1 in RUN and LAP.
  - `disp_hold` = 1 in LAP only.
- `count_clr` is a registered pulse:
  - high for exactly the one cycle following the edge that processes the clearing `ev_lr`;
  - never high for two consecutive cycles;
  - never high while `count_en` = 1.
- Reset values: `state` = IDLE, `count_en` = 0, `disp_hold` = 0, `count_clr` = 0. Synchronizer, debounce and edge registers clear to 0.
- Reset asserted mid-operation returns to IDLE immediately (asynchronously) and drops all outputs. A button already held when reset releases generates no event until it is released and pressed again, because the debounced level starts at 0 and must first rise.

## Timing
- Edge 0 is the first rising edge sampling a raw button high.
- Without the debouncer: the event is high during the cycle after edge 1, the state changes at edge 2, and `count_en` / `disp_hold` follow right after edge 2. A clearing `count_clr` is high from edge 2 to edge 3.
- With the debouncer: add `DEBOUNCE_CYCLES` to every figure above (state change at edge `DEBOUNCE_CYCLES`+2).
- Debounce counter:
  - counts cycles in which the synchronized input differs from the debounced level;
  - on reaching `DEBOUNCE_CYCLES`−1 it updates the level and clears;
  - any cycle with no difference clears it.
  - Width is ⌈log2(`DEBOUNCE_CYCLES`)⌉ bits; no wrap is possible.

## Configuration
- `STOPWATCH_CTRL_DEBOUNCE_EN`:
  - Defined: the debouncer is instantiated per button with the counter described above, and glitches shorter than `DEBOUNCE_CYCLES` are rejected.
  - Undefined: the debounced level is the synchronizer output directly. `DEBOUNCE_CYCLES` is unused, and every raw rising edge lasting ≥ 1 sampled cycle yields one event. The FSM is identical in both builds.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 with the macro defined, unless stated.
- Reset, then press `btn_ss` for 10 cycles: `state` goes 00 to 01 at edge 6 and `count_en` = 1. Holding for a further 20 cycles causes no other change.
- RUN, press `btn_lr`: `state` = 10, `disp_hold` = 1, `count_en` stays 1. Press `btn_lr` again: `state` = 01, `disp_hold` = 0.
- RUN, press `btn_ss`: PAUSE, `count_en` = 0. Then press `btn_lr`: IDLE with exactly one `count_clr` cycle. Press `btn_lr` in IDLE: one more `count_clr` pulse, state stays 00.
- Glitch rejection: a 3-cycle high pulse on `btn_ss` gives no state change. With the macro undefined, the same pulse moves the state to RUN at edge 2.
- Simultaneous presses in RUN (both raw inputs rise on the same edge): state goes to PAUSE, the lap is ignored, and `disp_hold` stays 0.
- Assert `rst` mid-LAP for 1 cycle while `btn_ss` is held: all outputs drop to 0 and state = 00. No event occurs until `btn_ss` is released and re-pressed.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and control outputs between the stopwatch sequencer and its environment.
// The master side drives the raw buttons; the slave side is the sequencer.
interface stopwatch_ctrl_if;
  logic       btn_ss;
  logic       btn_lr;
  logic       count_en;
  logic       count_clr;
  logic       disp_hold;
  logic [1:0] state;

  modport master (
    output btn_ss,
    output btn_lr,
    input  count_en,
    input  count_clr,
    input  disp_hold,
    input  state
  );

  modport slave (
    input  btn_ss,
    input  btn_lr,
    output count_en,
    output count_clr,
    output disp_hold,
    output state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button sync/debounce/edge detect feeding a 4-state FSM.
// Optional debouncer enabled by defining STOPWATCH_CTRL_DEBOUNCE_EN.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic            clk,
  input  logic            rst,
  stopwatch_ctrl_if.slave sw
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    LAP   = 2'b10,
    PAUSE = 2'b11
  } state_t;

  if (DEBOUNCE_CYCLES < 2) begin : g_cfg_err
    $error("stopwatch_ctrl: DEBOUNCE_CYCLES must be >= 2");
  end

  // Bit 0 carries start/stop, bit 1 carries lap/reset.
  logic [1:0] raw;
  logic [1:0] sync_p0;
  logic [1:0] sync_p1;
  logic [1:0] lvl;
  logic [1:0] lvl_q;
  logic [1:0] armed;
  logic [1:0] warm;
  logic [1:0] ev;
  logic       ev_ss;
  logic       ev_lr;

  assign raw = {sw.btn_lr, sw.btn_ss};

  // Stage p0/p1: two-flop synchronizer; warm marks when p1 holds real samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      warm    <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      warm    <= {warm[0], 1'b1};
    end
  end

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  // Debounce: level flips only after DEBOUNCE_CYCLES consecutive differing samples
  for (genvar i = 0; i < 2; i++) begin : g_db
    logic [CNT_W-1:0] cnt;
    logic             lvl_r;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt   <= '0;
        lvl_r <= 1'b0;
      end else if (sync_p1[i] != lvl_r) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          lvl_r <= sync_p1[i];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end

    assign lvl[i] = lvl_r;
  end
`else
  assign lvl = sync_p1;
`endif

  // Edge stage: a button only arms once it has been seen released, so a press
  // held through reset cannot fire an event when the level first rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q <= '0;
      armed <= '0;
    end else begin
      lvl_q <= lvl;
      armed <= armed | ({2{warm[1]}} & ~sync_p1 & ~lvl);
    end
  end

  assign ev    = lvl & ~lvl_q & armed;
  assign ev_ss = ev[0];
  assign ev_lr = ev[1];

  state_t state_q;
  state_t state_d;
  logic   clr_q;
  logic   clr_d;

  // FSM stage: state register and registered clear pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  // Start/stop takes priority over lap/reset when both arrive together.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev_ss)      state_d = RUN;
        else if (ev_lr) clr_d   = 1'b1;
      end
      RUN: begin
        if (ev_ss)      state_d = PAUSE;
        else if (ev_lr) state_d = LAP;
      end
      LAP: begin
        if (ev_ss)      state_d = PAUSE;
        else if (ev_lr) state_d = RUN;
      end
      PAUSE: begin
        if (ev_ss) begin
          state_d = RUN;
        end else if (ev_lr) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sw.state     = state_q;
  assign sw.count_en  = (state_q == RUN) || (state_q == LAP);
  assign sw.disp_hold = (state_q == LAP);
  assign sw.count_clr = clr_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with DEBOUNCE_CYCLES = 4.
// Latency expectations follow STOPWATCH_CTRL_DEBOUNCE_EN when it is defined.
module tb_stopwatch_ctrl;

  localparam int DB = 4;
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  localparam int LAT    = DB + 2;
  localparam bit DEB_ON = 1'b1;
`else
  localparam int LAT    = 2;
  localparam bit DEB_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stopwatch_ctrl_if sw ();

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw)
  );

  int   checks = 0;
  int   errors = 0;
  int   clr_cnt = 0;
  int   clr_bad = 0;
  int   hold_cnt = 0;
  logic clr_prev = 1'b0;
  logic [1:0] model_st = 2'b00;

  // Pulse-property monitor: counts clear cycles and illegal clear patterns.
  always @(negedge clk) begin
    if (!rst) begin
      if (sw.count_clr) clr_cnt++;
      if (sw.count_clr && sw.count_en) clr_bad++;
      if (sw.count_clr && clr_prev) clr_bad++;
      if (sw.disp_hold) hold_cnt++;
      clr_prev = sw.count_clr;
    end else begin
      clr_prev = 1'b0;
    end
  end

  // Press the selected buttons; returns just after the edge that changes state.
  task automatic press(input logic ss, input logic lr);
    @(negedge clk);
    if (ss) sw.btn_ss = 1'b1;
    if (lr) sw.btn_lr = 1'b1;
    repeat (LAT + 1) @(negedge clk);
  endtask

  task automatic release_all(input int extra);
    repeat (extra) @(negedge clk);
    sw.btn_ss = 1'b0;
    sw.btn_lr = 1'b0;
    repeat (LAT + 4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    sw.btn_ss = 1'b0;
    sw.btn_lr = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sw.state !== 2'b00) begin errors++; $display("FAIL reset_state got %0d want 0", sw.state); end
    checks++; if (sw.count_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", sw.count_en); end
    checks++; if (sw.count_clr !== 1'b0) begin errors++; $display("FAIL reset_clr got %b want 0", sw.count_clr); end
    checks++; if (sw.disp_hold !== 1'b0) begin errors++; $display("FAIL reset_hold got %b want 0", sw.disp_hold); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_start_hold;
    @(negedge clk);
    sw.btn_ss = 1'b1;
    repeat (LAT) @(negedge clk);
    checks++; if (sw.state !== 2'b00) begin errors++; $display("FAIL start_early got %0d want 0", sw.state); end
    @(negedge clk);
    checks++; if (sw.state !== 2'b01) begin errors++; $display("FAIL start_state got %0d want 1", sw.state); end
    checks++; if (sw.count_en !== 1'b1) begin errors++; $display("FAIL start_en got %b want 1", sw.count_en); end
    repeat (20) @(negedge clk);
    checks++; if (sw.state !== 2'b01) begin errors++; $display("FAIL start_held got %0d want 1", sw.state); end
    checks++; if (clr_cnt !== 0) begin errors++; $display("FAIL start_noclr got %0d want 0", clr_cnt); end
    release_all(0);
    model_st = 2'b01;
  endtask

  task automatic test_lap;
    press(1'b0, 1'b1);
    checks++; if (sw.state !== 2'b10) begin errors++; $display("FAIL lap_state got %0d want 2", sw.state); end
    checks++; if (sw.disp_hold !== 1'b1) begin errors++; $display("FAIL lap_hold got %b want 1", sw.disp_hold); end
    checks++; if (sw.count_en !== 1'b1) begin errors++; $display("FAIL lap_en got %b want 1", sw.count_en); end
    release_all(3);
    press(1'b0, 1'b1);
    checks++; if (sw.state !== 2'b01) begin errors++; $display("FAIL unlap_state got %0d want 1", sw.state); end
    checks++; if (sw.disp_hold !== 1'b0) begin errors++; $display("FAIL unlap_hold got %b want 0", sw.disp_hold); end
    release_all(3);
  endtask

  task automatic test_pause_clear;
    press(1'b1, 1'b0);
    checks++; if (sw.state !== 2'b11) begin errors++; $display("FAIL pause_state got %0d want 3", sw.state); end
    checks++; if (sw.count_en !== 1'b0) begin errors++; $display("FAIL pause_en got %b want 0", sw.count_en); end
    release_all(2);
    clr_cnt = 0;
    clr_bad = 0;
    press(1'b0, 1'b1);
    checks++; if (sw.state !== 2'b00) begin errors++; $display("FAIL clear_state got %0d want 0", sw.state); end
    checks++; if (sw.count_clr !== 1'b1) begin errors++; $display("FAIL clear_pulse got %b want 1", sw.count_clr); end
    @(negedge clk);
    checks++; if (sw.count_clr !== 1'b0) begin errors++; $display("FAIL clear_width got %b want 0", sw.count_clr); end
    release_all(2);
    checks++; if (clr_cnt !== 1) begin errors++; $display("FAIL clear_count got %0d want 1", clr_cnt); end
    press(1'b0, 1'b1);
    checks++; if (sw.state !== 2'b00) begin errors++; $display("FAIL idle_clear_state got %0d want 0", sw.state); end
    checks++; if (sw.count_clr !== 1'b1) begin errors++; $display("FAIL idle_clear_pulse got %b want 1", sw.count_clr); end
    release_all(2);
    checks++; if (clr_cnt !== 2) begin errors++; $display("FAIL idle_clear_count got %0d want 2", clr_cnt); end
    checks++; if (clr_bad !== 0) begin errors++; $display("FAIL clear_shape got %0d want 0", clr_bad); end
    model_st = 2'b00;
  endtask

  task automatic test_glitch;
    @(negedge clk);
    sw.btn_ss = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (sw.state !== (DEB_ON ? 2'b00 : 2'b01)) begin errors++; $display("FAIL glitch_edge2 got %0d want %0d", sw.state, DEB_ON ? 0 : 1); end
    sw.btn_ss = 1'b0;
    repeat (15) @(negedge clk);
    checks++; if (sw.state !== (DEB_ON ? 2'b00 : 2'b01)) begin errors++; $display("FAIL glitch_final got %0d want %0d", sw.state, DEB_ON ? 0 : 1); end
    model_st = DEB_ON ? 2'b00 : 2'b01;
  endtask

  task automatic test_simultaneous;
    if (model_st == 2'b00) begin
      press(1'b1, 1'b0);
      release_all(2);
    end
    checks++; if (sw.state !== 2'b01) begin errors++; $display("FAIL simul_pre got %0d want 1", sw.state); end
    hold_cnt = 0;
    press(1'b1, 1'b1);
    checks++; if (sw.state !== 2'b11) begin errors++; $display("FAIL simul_state got %0d want 3", sw.state); end
    checks++; if (sw.disp_hold !== 1'b0) begin errors++; $display("FAIL simul_hold got %b want 0", sw.disp_hold); end
    release_all(4);
    checks++; if (sw.state !== 2'b11) begin errors++; $display("FAIL simul_after got %0d want 3", sw.state); end
    checks++; if (hold_cnt !== 0) begin errors++; $display("FAIL simul_hold_seen got %0d want 0", hold_cnt); end
  endtask

  task automatic test_reset_mid_lap;
    press(1'b1, 1'b0);
    checks++; if (sw.state !== 2'b01) begin errors++; $display("FAIL resume_state got %0d want 1", sw.state); end
    release_all(2);
    press(1'b0, 1'b1);
    checks++; if (sw.state !== 2'b10) begin errors++; $display("FAIL midlap_pre got %0d want 2", sw.state); end
    release_all(2);
    @(negedge clk);
    sw.btn_ss = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (sw.state !== 2'b00) begin errors++; $display("FAIL async_state got %0d want 0", sw.state); end
    checks++; if (sw.count_en !== 1'b0) begin errors++; $display("FAIL async_en got %b want 0", sw.count_en); end
    checks++; if (sw.disp_hold !== 1'b0) begin errors++; $display("FAIL async_hold got %b want 0", sw.disp_hold); end
    checks++; if (sw.count_clr !== 1'b0) begin errors++; $display("FAIL async_clr got %b want 0", sw.count_clr); end
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (sw.state !== 2'b00) begin errors++; $display("FAIL held_thru_reset got %0d want 0", sw.state); end
    sw.btn_ss = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    checks++; if (sw.state !== 2'b00) begin errors++; $display("FAIL release_after_reset got %0d want 0", sw.state); end
    press(1'b1, 1'b0);
    checks++; if (sw.state !== 2'b01) begin errors++; $display("FAIL repress_state got %0d want 1", sw.state); end
    release_all(2);
    checks++; if (clr_bad !== 0) begin errors++; $display("FAIL final_clr_shape got %0d want 0", clr_bad); end
  endtask

  initial begin
    test_reset();
    test_start_hold();
    test_lap();
    test_pause_clear();
    test_glitch();
    test_simultaneous();
    test_reset_mid_lap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
